// File: rtl/fifo_stream_framer_if.sv
// Framer bus: show-ahead FIFO read port plus the valid/ready output stream.
// The master modport is the framer's view; slave is the surrounding system.
`timescale 1ns/1ps
interface fifo_stream_framer_if #(
  parameter int DATA_W = 8
);
  logic              fifo_rden;
  logic [DATA_W-1:0] fifo_rddata;
  logic              fifo_empty;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (
    output fifo_rden,
    input  fifo_rddata,
    input  fifo_empty,
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  fifo_rden,
    output fifo_rddata,
    output fifo_empty,
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/fifo_stream_framer.sv
// Drains a show-ahead FIFO into fixed-length valid/ready packets; a packet
// starved mid-way for TIMEOUT cycles is completed with PAD_WORD beats.
`timescale 1ns/1ps
module fifo_stream_framer #(
  parameter int                DATA_W   = 8,
  parameter int                PKT_LEN  = 16,
  parameter int                TIMEOUT  = 32,
  parameter logic [DATA_W-1:0] PAD_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_en,
  fifo_stream_framer_if.master bus,
  output logic                 o_padding,
  output logic                 o_pad_evt
);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int SW = $clog2(TIMEOUT + 2);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(PKT_LEN - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SW-1:0] STARVE_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_PAD} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [BW-1:0]     r_beat_cnt;
  logic [SW-1:0]     r_starve_cnt;
  logic              r_valid;
  logic              r_last;
  logic              r_pad_evt;
  logic [DATA_W-1:0] r_data;
  logic              w_slot_free;
  logic              w_load;
  logic              w_pop;
  logic              w_starved;
  logic              w_pkt_end;
  logic              w_enter_pad;

  assign w_slot_free = !r_valid | bus.ready;

  // rstn gates the load so the pop strobe is forced low while reset is held
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_starved    = 1'b0;
    w_enter_pad  = 1'b0;
    w_pkt_end    = (r_beat_cnt == LAST_BEAT);
    if (rstn && i_en && w_slot_free) begin
      if (r_state == S_PAD) begin
        w_load = 1'b1;
      end else begin
        w_load    = !bus.fifo_empty;
        w_pop     = !bus.fifo_empty;
        w_starved = bus.fifo_empty;
      end
    end
    case (r_state)
      S_IDLE: begin
        if (w_load) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_load && w_pkt_end) begin
          w_state_next = S_IDLE;
        end else if (w_starved && (TIMEOUT != 0) && (r_starve_cnt == STARVE_LIM)) begin
          w_state_next = S_PAD;
          w_enter_pad  = 1'b1;
        end
      end
      S_PAD: begin
        if (w_load && w_pkt_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_pad_evt    <= 1'b0;
      r_beat_cnt   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_pad_evt <= w_enter_pad;
      if (w_load) begin
        r_data     <= (r_state == S_PAD) ? PAD_WORD : bus.fifo_rddata;
        r_valid    <= 1'b1;
        r_last     <= w_pkt_end;
        r_beat_cnt <= w_pkt_end ? '0 : r_beat_cnt + 1'b1;
      end else if (i_en && w_slot_free) begin
        r_valid <= 1'b0;
      end
      // starvation only accrues mid-packet while the output slot could take a beat
      if (r_state != S_STREAM || w_pop) begin
        r_starve_cnt <= '0;
      end else if (w_starved && r_starve_cnt != STARVE_MAX) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign bus.fifo_rden = w_pop;
  assign bus.valid     = r_valid;
  assign bus.data      = r_data;
  assign bus.last      = r_last;
  assign o_padding     = (r_state == S_PAD);
  assign o_pad_evt     = r_pad_evt;
endmodule

// File: tb/tb_fifo_stream_framer.sv
// Bench for fifo_stream_framer: directed scenarios plus random traffic
// scored against a packet-level model of the expected output stream.
`timescale 1ns/1ps
module tb_fifo_stream_framer;
  localparam int        DW  = 8;
  localparam int        PL  = 4;
  localparam int        TO  = 5;
  localparam logic [7:0] PAD = 8'h5A;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_en = 1'b0;
  logic o_padding;
  logic o_pad_evt;

  fifo_stream_framer_if #(.DATA_W(DW)) bus ();

  fifo_stream_framer #(
    .DATA_W(DW), .PKT_LEN(PL), .TIMEOUT(TO), .PAD_WORD(PAD)
  ) dut (
    .clk(clk), .rstn(rstn), .i_en(i_en), .bus(bus),
    .o_padding(o_padding), .o_pad_evt(o_pad_evt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         pos = 0;
  bit         pad_mode = 0;
  int         cyc = 0;
  int         acc_cnt = 0, first_acc = 0, last_acc = 0;
  int         evt_cnt = 0, pad_pkts = 0;
  logic       s_rden, s_valid, s_last, s_pad, s_evt, s_ready;
  logic [7:0] s_data;
  bit         p_hold = 0;
  logic [7:0] p_data;
  logic       p_last;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fifo_drive();
    bus.fifo_empty  = (fifo_q.size() == 0);
    bus.fifo_rddata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_drive();
  endtask

  // One clock: sample at negedge, score accepted beat, pop FIFO model at posedge.
  task automatic cycle();
    @(negedge clk);
    s_rden = bus.fifo_rden; s_valid = bus.valid; s_data = bus.data;
    s_last = bus.last; s_pad = o_padding; s_evt = o_pad_evt; s_ready = bus.ready;
    if (s_evt) evt_cnt++;
    if (fifo_q.size() == 0) check_val("pop_on_empty", s_rden, 0);
    if (s_valid && !s_ready) check_val("pop_while_full", s_rden, 0);
    if (p_hold) begin
      check_val("hold_valid", s_valid, 1);
      check_val("hold_data", s_data, p_data);
      check_val("hold_last", s_last, p_last);
    end
    p_hold = s_valid && !s_ready;
    p_data = s_data;
    p_last = s_last;
    if (s_valid && s_ready) begin
      $display("beat cyc=%0d pos=%0d data=0x%02h last=%0b", cyc, pos, s_data, s_last);
      if (!pad_mode && pos != 0 && s_data == PAD) begin
        pad_mode = 1;
        pad_pkts++;
      end
      if (pad_mode) check_val("pad_data", s_data, PAD);
      else if (exp_q.size() == 0) check_val("beat_queue_nonempty", exp_q.size(), 1);
      else check_val("beat_data", s_data, exp_q.pop_front());
      check_val("beat_last", s_last, (pos == PL - 1));
      pos = (pos + 1) % PL;
      if (pos == 0) pad_mode = 0;
      acc_cnt++;
      if (acc_cnt == 1) first_acc = cyc;
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
    if (s_rden && fifo_q.size() != 0) fifo_q.delete(0);
    fifo_drive();
    cyc++;
  endtask

  task automatic run_beats(input string tag, input int n, input int budget, input bit bp);
    acc_cnt = 0;
    for (int k = 0; k < budget && acc_cnt < n; k++) begin
      bus.ready = bp ? (k % 3 == 0) : 1'b1;
      cycle();
    end
    check_val({tag, "_beats"}, acc_cnt, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int prob;
    int probs[5] = '{0, 5, 30, 70, 100};
    logic [7:0] w;

    bus.ready = 1'b0;
    fifo_drive();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", bus.valid, 0);
    check_val("rst_data", bus.data, 0);
    check_val("rst_last", bus.last, 0);
    check_val("rst_padding", o_padding, 0);
    check_val("rst_pad_evt", o_pad_evt, 0);
    rstn = 1'b1;
    i_en = 1'b1;

    // straight streaming, two packets back to back
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    start = cyc;
    run_beats("t1", 8, 30, 0);
    check_val("t1_latency", first_acc - start, 1);
    check_val("t1_no_gap", last_acc - first_acc, 7);
    check_val("t1_fifo_empty", fifo_q.size(), 0);

    // backpressure pattern
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    run_beats("t2", 8, 60, 1);
    check_val("t2_fifo_empty", fifo_q.size(), 0);

    // timeout padding
    push(8'hA1);
    push(8'hA2);
    bus.ready = 1'b1;
    acc_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      check_val("t3_pad_evt", s_evt, (k == 7));
      check_val("t3_padding", s_pad, (k == 7 || k == 8));
    end
    check_val("t3_beats", acc_cnt, 4);
    check_val("t3_pos", pos, 0);

    // starvation between packets never pads
    for (int k = 0; k < 100; k++) begin
      cycle();
      check_val("t4_pad_evt", s_evt, 0);
      check_val("t4_valid", s_valid, 0);
    end

    // asynchronous reset in the middle of a packet
    push(8'h31); push(8'h32); push(8'h33);
    bus.ready = 1'b1;
    acc_cnt = 0;
    for (int k = 0; k < 10 && acc_cnt < 2; k++) cycle();
    check_val("t5_pre_beats", acc_cnt, 2);
    check_val("t5_valid_before", bus.valid, 1);
    #1;
    rstn = 1'b0;
    #1;
    check_val("t5_valid_async", bus.valid, 0);
    check_val("t5_data_async", bus.data, 0);
    check_val("t5_last_async", bus.last, 0);
    fifo_q.delete();
    exp_q.delete();
    pos = 0;
    pad_mode = 0;
    p_hold = 0;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    #1;
    check_val("t5_rden_in_reset", bus.fifo_rden, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    run_beats("t5", 4, 20, 0);

    // enable low with a beat parked in the output register
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    bus.ready = 1'b0;
    cycle();
    cycle();
    check_val("t6_valid_parked", s_valid, 1);
    i_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check_val("t6_valid", s_valid, 1);
      check_val("t6_data", s_data, 8'h50);
      check_val("t6_rden", s_rden, 0);
      check_val("t6_pad_evt", s_evt, 0);
    end
    check_val("t6_fifo_level", fifo_q.size(), 7);
    i_en = 1'b1;
    run_beats("t6", 8, 40, 0);

    // random traffic with bursty producer and random enable/ready
    prob = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) prob = probs[$urandom_range(4)];
      i_en = ($urandom % 16) != 0;
      bus.ready = i_en && (($urandom % 4) != 0);
      if (fifo_q.size() < 32 && $urandom_range(99) < prob) begin
        w = 8'($urandom_range(255));
        if (w == PAD) w = w ^ 8'h01;
        push(w);
      end
      cycle();
    end
    i_en = 1'b1;
    bus.ready = 1'b1;
    repeat (80) cycle();
    check_val("rnd_fifo_empty", fifo_q.size(), 0);
    check_val("rnd_all_delivered", exp_q.size(), 0);
    check_val("rnd_pkt_complete", pos, 0);
    check_val("rnd_pad_evt_count", evt_cnt, pad_pkts);
    check_val("rnd_padding_idle", o_padding, 0);
    check_val("rnd_valid_idle", bus.valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
